// File: rtl/eth_sd_sector_packer_if.sv
// Ethernet-to-SD sector packer bus: FIFO read side, SD write side, status.
// The master modport is the packer; the slave modport is its environment.
interface eth_sd_sector_packer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  flush;
    logic                  sd_wr_start;
    logic [31:0]           sd_wr_sec_addr;
    logic                  sd_wr_data_req;
    logic [DATA_WIDTH-1:0] sd_wr_data;
    logic                  sd_wr_done;
    logic                  busy;
    logic [31:0]           sector_cnt;
    logic                  err_req;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        input  flush,
        output sd_wr_start,
        output sd_wr_sec_addr,
        input  sd_wr_data_req,
        output sd_wr_data,
        input  sd_wr_done,
        output busy,
        output sector_cnt,
        output err_req
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        output flush,
        input  sd_wr_start,
        input  sd_wr_sec_addr,
        output sd_wr_data_req,
        input  sd_wr_data,
        output sd_wr_done,
        input  busy,
        input  sector_cnt,
        input  err_req
    );
endinterface

// File: rtl/eth_sd_sector_packer.sv
// Collects FIFO words into a one-sector buffer and streams each full
// (or flush-padded) sector to the SD write controller at rising addresses.
module eth_sd_sector_packer #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          SECTOR_WORDS = 128,
    parameter logic [31:0] START_SECTOR = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_sd_sector_packer_if.master bus
);
    localparam int AW = $clog2(SECTOR_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(SECTOR_WORDS);
    localparam logic [CW-1:0] LAST = CW'(SECTOR_WORDS - 1);

    typedef enum logic [2:0] {
        FILL,
        PAD,
        START,
        XFER,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         rd_issued;
    logic [CW-1:0]         fill_cnt;
    logic [CW-1:0]         req_cnt;
    logic                  flush_pend;
    logic                  rd_pend;
    logic                  rd_fire;
    logic                  start_q;
    logic                  err_q;
    logic [31:0]           addr_q;
    logic [31:0]           sec_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] mem [SECTOR_WORDS];

    logic in_fill;
    logic flush_svc;
    logic to_pad;
    logic rd_en;
    logic req_ok;

    // A pending flush is only acted on once no FIFO read is in flight;
    // reads are held off on the cycle that commits to padding.
    always_comb begin
        in_fill   = (state == FILL);
        flush_svc = in_fill && flush_pend && (rd_issued == fill_cnt);
        to_pad    = flush_svc && (fill_cnt != '0);
        rd_en     = in_fill && !rst && !bus.fifo_rd_empty
                    && (rd_issued < FULL) && !to_pad;
        req_ok    = bus.sd_wr_data_req && (state == XFER);
    end

    assign bus.fifo_rd_en     = rd_en;
    assign bus.sd_wr_start    = start_q;
    assign bus.sd_wr_sec_addr = addr_q;
    assign bus.sd_wr_data     = data_q;
    assign bus.sector_cnt     = sec_cnt_q;
    assign bus.err_req        = err_q;
    assign bus.busy           = !(in_fill && (fill_cnt == '0));

    // Sector buffer: FIFO capture or zero padding, synchronous read port.
    always_ff @(posedge clk) begin
        if (rd_pend) begin
            mem[fill_cnt[AW-1:0]] <= bus.fifo_rd_data;
        end else if (state == PAD) begin
            mem[fill_cnt[AW-1:0]] <= '0;
        end
        if (req_ok) begin
            mem_q <= mem[req_cnt[AW-1:0]];
        end
    end

    // Sector FSM with counters, flush bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            rd_issued  <= '0;
            fill_cnt   <= '0;
            req_cnt    <= '0;
            flush_pend <= 1'b0;
            rd_pend    <= 1'b0;
            rd_fire    <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= START_SECTOR;
            sec_cnt_q  <= '0;
            data_q     <= '0;
        end else begin
            start_q <= 1'b0;
            rd_pend <= rd_en;
            rd_fire <= req_ok;
            if (rd_fire) begin
                data_q <= mem_q;
            end
            if (bus.sd_wr_data_req && (state != XFER)) begin
                err_q <= 1'b1;
            end
            if (rd_en) begin
                rd_issued <= rd_issued + 1'b1;
            end
            if (bus.flush) begin
                flush_pend <= 1'b1;
            end else if (flush_svc) begin
                flush_pend <= 1'b0;
            end
            unique case (state)
                FILL: begin
                    if (rd_pend) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST) begin
                            state   <= START;
                            start_q <= 1'b1;
                        end
                    end else if (to_pad) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST) begin
                        state   <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    state <= XFER;
                end
                XFER: begin
                    if (req_ok) begin
                        req_cnt <= req_cnt + 1'b1;
                        if (req_cnt == LAST) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (bus.sd_wr_done) begin
                        addr_q    <= addr_q + 32'd1;
                        sec_cnt_q <= sec_cnt_q + 32'd1;
                        rd_issued <= '0;
                        fill_cnt  <= '0;
                        req_cnt   <= '0;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule
